// File: rtl/dispatch_pkg.sv
// Shared types and constants for the dispatch controller: FU indices, queue entry
// layout and a one-hot check used on the decode FU select.
package dispatch_pkg;

  localparam int unsigned NUM_FU = 4;
  localparam int unsigned FU_ALU = 0;
  localparam int unsigned FU_LSU = 1;
  localparam int unsigned FU_MUL = 2;
  localparam int unsigned FU_BR  = 3;

  localparam int unsigned DISP_XLEN   = 32;
  localparam int unsigned DISP_PREG_W = 5;

  typedef struct packed {
    logic [DISP_XLEN-1:0]   pc;
    logic [NUM_FU-1:0]      fu;
    logic [DISP_PREG_W-1:0] prs1;
    logic [DISP_PREG_W-1:0] prs2;
    logic [DISP_PREG_W-1:0] prd;
  } disp_entry_t;

  function automatic logic is_onehot(input logic [NUM_FU-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (v[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return seen && !multi;
  endfunction

endpackage

// File: rtl/fu_credit_cnt.sv
// Credit counter for one reservation station: starts full, spends on dispatch,
// refills on free, holds at full and flags an overflowing free.
module fu_credit_cnt #(
  parameter int unsigned RS_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic dispatch,
  input  logic free,
  output logic zero,
  output logic overflow
);

  localparam int unsigned CW = $clog2(RS_DEPTH + 1);
  localparam logic [CW-1:0] Full = CW'(RS_DEPTH);

  logic [CW-1:0] credit_q, credit_d;

  always_comb begin
    credit_d = credit_q;
    overflow = 1'b0;
    if (flush) begin
      // Reservation stations flush alongside us, so every entry comes back.
      credit_d = Full;
    end else if (dispatch && !free) begin
      credit_d = credit_q - CW'(1);
    end else if (free && !dispatch) begin
      if (credit_q == Full) begin
        overflow = 1'b1;
      end else begin
        credit_d = credit_q + CW'(1);
      end
    end
  end

  assign zero = (credit_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= Full;
    end else begin
      credit_q <= credit_d;
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// In-order dispatch queue between rename and the four FU reservation stations,
// gated by per-FU credits. Optional stall counter under DISPATCH_PERF_CNT_EN.
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int unsigned QDEPTH   = 2,
  parameter int unsigned RS_DEPTH = 4,
  parameter int unsigned PREG_W   = DISP_PREG_W,
  parameter int unsigned XLEN     = DISP_XLEN
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [XLEN-1:0]   dec_pc_i,
  input  logic [3:0]        dec_fu_i,
  input  logic [PREG_W-1:0] dec_prs1_i,
  input  logic [PREG_W-1:0] dec_prs2_i,
  input  logic [PREG_W-1:0] dec_prd_i,
  output logic [3:0]        disp_valid_o,
  output logic [XLEN-1:0]   disp_pc_o,
  output logic [PREG_W-1:0] disp_prs1_o,
  output logic [PREG_W-1:0] disp_prs2_o,
  output logic [PREG_W-1:0] disp_prd_o,
  input  logic [3:0]        rs_free_i,
  output logic              err_o
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  if (XLEN != DISP_XLEN || PREG_W != DISP_PREG_W) begin : g_width_chk
    $error("dispatch_ctrl: XLEN/PREG_W must match the dispatch_pkg entry layout");
  end
  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_depth_chk
    $error("dispatch_ctrl: QDEPTH must be a power of two >= 2");
  end

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam logic [CntW-1:0] QFull = CntW'(QDEPTH);

  disp_entry_t           mem_q [QDEPTH];
  disp_entry_t           head;
  disp_entry_t           entry_in;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  empty;
  logic                  push_acc;
  logic                  push;
  logic                  pop;
  logic                  bad_fu;
  logic [NUM_FU-1:0]     disp_valid;
  logic [NUM_FU-1:0]     cred_zero;
  logic [NUM_FU-1:0]     cred_ovf;
  logic                  err_q;

  assign empty       = (count_q == '0);
  assign dec_ready_o = (count_q != QFull) && !flush_i;
  assign push_acc    = dec_valid_i && dec_ready_o;
  // A malformed FU select is consumed so decode never wedges on it.
  assign push        = push_acc && is_onehot(dec_fu_i);
  assign bad_fu      = push_acc && !is_onehot(dec_fu_i);
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    entry_in      = '0;
    entry_in.pc   = dec_pc_i;
    entry_in.fu   = dec_fu_i;
    entry_in.prs1 = dec_prs1_i;
    entry_in.prs2 = dec_prs2_i;
    entry_in.prd  = dec_prd_i;
  end

  always_comb begin
    disp_valid = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      disp_valid[k] = !empty && head.fu[k] && !cred_zero[k] && !flush_i;
    end
  end

  assign pop          = |disp_valid;
  assign disp_valid_o = disp_valid;

  always_comb begin
    disp_pc_o   = '0;
    disp_prs1_o = '0;
    disp_prs2_o = '0;
    disp_prd_o  = '0;
    if (!empty) begin
      disp_pc_o   = head.pc;
      disp_prs1_o = head.prs1;
      disp_prs2_o = head.prs2;
      disp_prd_o  = head.prd;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= bad_fu || (|cred_ovf);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

  assign err_o = err_q;

  for (genvar k = 0; k < NUM_FU; k++) begin : g_credit
    fu_credit_cnt #(
      .RS_DEPTH(RS_DEPTH)
    ) u_credit (
      .clk     (clk_i),
      .rst_n   (reset_i),
      .flush   (flush_i),
      .dispatch(disp_valid[k]),
      .free    (rs_free_i[k]),
      .zero    (cred_zero[k]),
      .overflow(cred_ovf[k])
    );
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic        head_blocked;
  logic [31:0] stall_cnt_q;

  assign head_blocked = !empty && (|(head.fu & cred_zero));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_cnt_q <= '0;
    end else if (head_blocked && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: a per-cycle vector table plus hand-written
// sequences for in-order stall, flush and asynchronous reset.
module tb_dispatch_ctrl;
  import dispatch_pkg::*;

  localparam logic [3:0] ALU  = 4'b0001 << FU_ALU;
  localparam logic [3:0] LSU  = 4'b0001 << FU_LSU;
  localparam logic [3:0] MUL  = 4'b0001 << FU_MUL;
  localparam logic [3:0] BR   = 4'b0001 << FU_BR;
  localparam logic [3:0] NONE = 4'b0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [3:0]  dec_fu;
  logic [4:0]  dec_prs1, dec_prs2, dec_prd;
  logic [3:0]  disp_valid;
  logic [31:0] disp_pc;
  logic [4:0]  disp_prs1, disp_prs2, disp_prd;
  logic [3:0]  rs_free;
  logic        err;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dispatch_ctrl #(
    .QDEPTH  (2),
    .RS_DEPTH(4),
    .PREG_W  (5),
    .XLEN    (32)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_n),
    .flush_i     (flush),
    .dec_valid_i (dec_valid),
    .dec_ready_o (dec_ready),
    .dec_pc_i    (dec_pc),
    .dec_fu_i    (dec_fu),
    .dec_prs1_i  (dec_prs1),
    .dec_prs2_i  (dec_prs2),
    .dec_prd_i   (dec_prd),
    .disp_valid_o(disp_valid),
    .disp_pc_o   (disp_pc),
    .disp_prs1_o (disp_prs1),
    .disp_prs2_o (disp_prs2),
    .disp_prd_o  (disp_prd),
    .rs_free_i   (rs_free),
    .err_o       (err)
`ifdef DISPATCH_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  typedef struct {
    logic        valid;
    logic [3:0]  fu;
    logic [31:0] pc;
    logic [4:0]  prd;
    logic [3:0]  free;
    logic [3:0]  e_disp;
    logic        e_ready;
    logic [31:0] e_pc;
    logic [4:0]  e_prd;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  // Source regs are derived from pc/prd so they map 0 -> 0 for the empty case.
  function automatic logic [4:0] rot5(input logic [4:0] x);
    return {x[0], x[4:1]};
  endfunction

  function automatic logic [4:0] mix5(input logic [31:0] pc, input logic [4:0] prd);
    return pc[4:0] ^ prd;
  endfunction

  function automatic vec_t v(input logic valid, input logic [3:0] fu, input logic [31:0] pc,
                             input logic [4:0] prd, input logic [3:0] free,
                             input logic [3:0] e_disp, input logic e_ready,
                             input logic [31:0] e_pc, input logic [4:0] e_prd,
                             input logic e_err);
    vec_t r;
    r.valid = valid; r.fu = fu; r.pc = pc; r.prd = prd; r.free = free;
    r.e_disp = e_disp; r.e_ready = e_ready; r.e_pc = e_pc; r.e_prd = e_prd; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ed, input logic er,
                         input logic [31:0] epc, input logic [4:0] eprd, input logic ee);
    chk({tag, ".disp"},  32'(disp_valid), 32'(ed));
    chk({tag, ".ready"}, 32'(dec_ready),  32'(er));
    chk({tag, ".pc"},    disp_pc,         epc);
    chk({tag, ".prd"},   32'(disp_prd),   32'(eprd));
    chk({tag, ".prs1"},  32'(disp_prs1),  32'(rot5(eprd)));
    chk({tag, ".prs2"},  32'(disp_prs2),  32'(mix5(epc, eprd)));
    chk({tag, ".err"},   32'(err),        32'(ee));
  endtask

  // Applies inputs just after a rising edge and returns at the falling edge.
  task automatic drive(input logic valid, input logic [3:0] fu, input logic [31:0] pc,
                       input logic [4:0] prd, input logic [3:0] free, input logic fl);
    dec_valid = valid;
    dec_fu    = fu;
    dec_pc    = pc;
    dec_prd   = prd;
    dec_prs1  = rot5(prd);
    dec_prs2  = mix5(pc, prd);
    rs_free   = free;
    flush     = fl;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, NONE, 32'h0, 5'd0, NONE, 1'b0);
  endtask

  initial begin
    // Single-cycle vectors; err columns reflect the previous row's inputs.
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(1, ALU,  32'h100, 5'd7,  NONE, NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, ALU,  1, 32'h100, 5'd7,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  ALU,  NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(1, ALU,  32'h200, 5'd1,  NONE, NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(1, ALU,  32'h201, 5'd2,  NONE, ALU,  1, 32'h200, 5'd1,  0));
    vecs.push_back(v(1, ALU,  32'h202, 5'd3,  NONE, ALU,  1, 32'h201, 5'd2,  0));
    vecs.push_back(v(1, ALU,  32'h203, 5'd4,  NONE, ALU,  1, 32'h202, 5'd3,  0));
    vecs.push_back(v(1, ALU,  32'h204, 5'd5,  NONE, ALU,  1, 32'h203, 5'd4,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h204, 5'd5,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  ALU,  NONE, 1, 32'h204, 5'd5,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, ALU,  1, 32'h204, 5'd5,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h0,   5'd0,  0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, NONE, 32'h0, 5'd0, ALU, NONE, 1, 32'h0, 5'd0, 0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  MUL,  NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h0,   5'd0,  1));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(1, 4'b0101, 32'h300, 5'd6, NONE, NONE, 1, 32'h0, 5'd0,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h0,   5'd0,  1));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(1, LSU,  32'h400, 5'd8,  NONE, NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(1, LSU,  32'h401, 5'd9,  NONE, LSU,  1, 32'h400, 5'd8,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, LSU,  1, 32'h401, 5'd9,  0));
    vecs.push_back(v(1, LSU,  32'h402, 5'd10, NONE, NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  LSU,  LSU,  1, 32'h402, 5'd10, 0));
    vecs.push_back(v(1, LSU,  32'h403, 5'd11, NONE, NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(1, LSU,  32'h404, 5'd12, NONE, LSU,  1, 32'h403, 5'd11, 0));
    vecs.push_back(v(1, LSU,  32'h405, 5'd13, NONE, LSU,  1, 32'h404, 5'd12, 0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h405, 5'd13, 0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  LSU,  NONE, 1, 32'h405, 5'd13, 0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, LSU,  1, 32'h405, 5'd13, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, NONE, 32'h0, 5'd0, LSU, NONE, 1, 32'h0, 5'd0, 0));
    vecs.push_back(v(1, NONE, 32'h310, 5'd3,  NONE, NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h0,   5'd0,  1));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h0,   5'd0,  0));
    // Bad select and credit overflow together must still give one pulse.
    vecs.push_back(v(1, 4'b1100, 32'h320, 5'd3, BR, NONE, 1, 32'h0,   5'd0,  0));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h0,   5'd0,  1));
    vecs.push_back(v(0, NONE, 32'h0,   5'd0,  NONE, NONE, 1, 32'h0,   5'd0,  0));

    reset_n = 1'b0;
    drive(1'b0, NONE, 32'h0, 5'd0, NONE, 1'b0);
    #8;
    chk_out("reset", NONE, 1'b1, 32'h0, 5'd0, 1'b0);
    tick();
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].fu, vecs[i].pc, vecs[i].prd, vecs[i].free, 1'b0);
      chk_out($sformatf("vec%0d", i), vecs[i].e_disp, vecs[i].e_ready, vecs[i].e_pc,
              vecs[i].e_prd, vecs[i].e_err);
      tick();
    end

    // In-order stall: MUL head without credit blocks a younger ALU entry.
    drive(1, MUL, 32'h500, 5'd11, NONE, 0); chk_out("ino0", NONE, 1, 32'h0,   5'd0,  0); tick();
    drive(1, MUL, 32'h501, 5'd12, NONE, 0); chk_out("ino1", MUL,  1, 32'h500, 5'd11, 0); tick();
    drive(1, MUL, 32'h502, 5'd13, NONE, 0); chk_out("ino2", MUL,  1, 32'h501, 5'd12, 0); tick();
    drive(1, MUL, 32'h503, 5'd14, NONE, 0); chk_out("ino3", MUL,  1, 32'h502, 5'd13, 0); tick();
    drive(1, MUL, 32'h504, 5'd15, NONE, 0); chk_out("ino4", MUL,  1, 32'h503, 5'd14, 0); tick();
    drive(1, ALU, 32'h600, 5'd16, NONE, 0); chk_out("ino5", NONE, 1, 32'h504, 5'd15, 0); tick();
    idle();                                 chk_out("ino6", NONE, 0, 32'h504, 5'd15, 0); tick();
    drive(1, ALU, 32'h610, 5'd17, MUL, 0);  chk_out("ino7", NONE, 0, 32'h504, 5'd15, 0); tick();
    idle();                                 chk_out("ino8", MUL,  0, 32'h504, 5'd15, 0); tick();
    idle();                                 chk_out("ino9", ALU,  1, 32'h600, 5'd16, 0); tick();
    idle();                                 chk_out("ino10", NONE, 1, 32'h0,  5'd0,  0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, NONE, 32'h0, 5'd0, MUL, 0); tick();
    end

    // Flush with two entries queued and the LSU head holding one credit.
    drive(1, LSU, 32'h700, 5'd17, NONE, 0); chk_out("fl0", NONE, 1, 32'h0,   5'd0,  0); tick();
    drive(1, LSU, 32'h701, 5'd18, NONE, 0); chk_out("fl1", LSU,  1, 32'h700, 5'd17, 0); tick();
    drive(1, LSU, 32'h702, 5'd19, NONE, 0); chk_out("fl2", LSU,  1, 32'h701, 5'd18, 0); tick();
    drive(1, LSU, 32'h703, 5'd20, NONE, 0); chk_out("fl3", LSU,  1, 32'h702, 5'd19, 0); tick();
    drive(1, LSU, 32'h704, 5'd21, NONE, 0); chk_out("fl4", LSU,  1, 32'h703, 5'd20, 0); tick();
    drive(1, LSU, 32'h705, 5'd22, NONE, 0); chk_out("fl5", NONE, 1, 32'h704, 5'd21, 0); tick();
    idle(); rs_free = LSU;                  chk_out("fl6", NONE, 0, 32'h704, 5'd21, 0); tick();
    drive(1, ALU, 32'h7f0, 5'd1, LSU, 1);   chk_out("fl7", NONE, 0, 32'h704, 5'd21, 0); tick();
    idle();                                 chk_out("fl8", NONE, 1, 32'h0,   5'd0,  0); tick();
    drive(1, ALU, 32'h710, 5'd2, NONE, 1);  chk_out("fl9", NONE, 0, 32'h0,   5'd0,  0); tick();
    idle();                                 chk_out("fl10", NONE, 1, 32'h0,  5'd0,  0); tick();
    drive(1, LSU, 32'h720, 5'd3, NONE, 0);  chk_out("fl11", NONE, 1, 32'h0,   5'd0, 0); tick();
    drive(1, LSU, 32'h721, 5'd4, NONE, 0);  chk_out("fl12", LSU,  1, 32'h720, 5'd3, 0); tick();
    drive(1, LSU, 32'h722, 5'd5, NONE, 0);  chk_out("fl13", LSU,  1, 32'h721, 5'd4, 0); tick();
    drive(1, LSU, 32'h723, 5'd6, NONE, 0);  chk_out("fl14", LSU,  1, 32'h722, 5'd5, 0); tick();
    idle();                                 chk_out("fl15", LSU,  1, 32'h723, 5'd6, 0); tick();

    // Asynchronous reset with a dispatch pending, then with err high.
    drive(1, ALU, 32'h800, 5'd23, NONE, 0); chk_out("rs0", NONE, 1, 32'h0,   5'd0,  0); tick();
    idle();                                 chk_out("rs1", ALU,  1, 32'h800, 5'd23, 0);
    #1 reset_n = 1'b0;
    #1 chk_out("rs2", NONE, 1, 32'h0, 5'd0, 0);
    tick();
    reset_n = 1'b1;
    idle();                                 chk_out("rs3", NONE, 1, 32'h0,   5'd0,  0); tick();
    drive(1, 4'b0011, 32'h810, 5'd1, NONE, 0); chk_out("rs4", NONE, 1, 32'h0, 5'd0, 0); tick();
    idle();                                 chk_out("rs5", NONE, 1, 32'h0,   5'd0,  1);
    #1 reset_n = 1'b0;
    #1 chk_out("rs6", NONE, 1, 32'h0, 5'd0, 0);
    tick();
    reset_n = 1'b1;
    drive(1, BR, 32'h820, 5'd9, NONE, 0);   chk_out("rs7", NONE, 1, 32'h0,   5'd0,  0); tick();
    idle();                                 chk_out("rs8", BR,   1, 32'h820, 5'd9,  0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Sits between decode/rename and the four functional-unit reservation stations (ALU, LSU, MUL, BR).
- Buffers renamed instructions in a small in-order queue.
- Tracks free reservation-station entries per FU with credit counters; dispatches the queue head only when its target FU has a credit.
- Back-pressures decode with a ready signal. Supports a pipeline flush.

Parameters:
- QDEPTH, 2: dispatch queue entries (power of two, ≥2).
- RS_DEPTH, 4: entries per FU reservation station; this is also the initial credit value.
- PREG_W, 5: physical register address width.
- XLEN, 32: PC width.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous reset, active-low (0 = reset).
- flush_i  in  1  pipeline flush, synchronous.
- dec_valid_i  in  1  decode offers an instruction.
- dec_ready_o  out  1  controller accepts; a transfer occurs when valid && ready.
- dec_pc_i  in  XLEN  instruction PC.
- dec_fu_i  in  4  FU select, one-hot {br,mul,lsu,alu}.
- dec_prs1_i  in  PREG_W  physical source 1.
- dec_prs2_i  in  PREG_W  physical source 2.
- dec_prd_i  in  PREG_W  physical destination.
- disp_valid_o  out  4  per-FU dispatch strobe; at most one bit set.
- disp_pc_o  out  XLEN  head PC.
- disp_prs1_o  out  PREG_W  head physical source 1.
- disp_prs2_o  out  PREG_W  head physical source 2.
- disp_prd_o  out  PREG_W  head physical destination.
- rs_free_i  in  4  per-FU pulse: one RS entry freed this cycle.
- err_o  out  1  one-cycle pulse: bad FU select dropped, or credit overflow.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - queue empty; read and write pointers 0.
  - all credits = RS_DEPTH.
  - dec_ready_o = 1, disp_valid_o = 0, err_o = 0.
  - payload outputs = 0.
- Queue is an in-order circular buffer with count register; pointers wrap modulo QDEPTH.
- dec_ready_o = (count != QDEPTH) && !flush_i. It is registered-count based, with no combinational path from disp or rs_free.
- Push on dec_valid_i && dec_ready_o.
  - If dec_fu_i is not one-hot (zero or multiple bits), the instruction is consumed but not enqueued, and err_o pulses next cycle.
- Head dispatch is combinational from queue state:
  - disp_valid_o[k] = !empty && head_fu[k] && credit[k] != 0 && !flush_i.
  - Payload outputs always show the head entry; they read 0 when the queue is empty.
  - The RS must accept any asserted strobe (credit guarantees space). The head pops in that cycle.
- Latency: an instruction pushed in cycle N is dispatchable in cycle N+1 at the earliest. One dispatch per cycle maximum.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal when full only if ready was high, which it is not; so a full queue never pushes.
- Strict in-order: a head blocked on credit stalls all younger entries, even those bound for other FUs.
- Credits: credit[k]_next = credit[k] − dispatch[k] + rs_free_i[k].
  - Simultaneous dispatch and free leaves the credit unchanged.
  - A free arriving when credit[k] == RS_DEPTH (with no dispatch) is ignored, credit is held, and err_o pulses next cycle.
  - Credit width is clog2(RS_DEPTH+1).
- Flush (flush_i=1):
  - in that cycle: no push, no dispatch, rs_free_i ignored.
  - next cycle: queue empty, all credits = RS_DEPTH (reservation stations flush concurrently).
- Reset mid-operation overrides flush and all traffic; in-flight entries are discarded.
- err_o is registered, one cycle wide; multiple error causes in one cycle produce a single pulse.

Optional Feature:
- Macro DISPATCH_PERF_CNT_EN.
- Defined: adds output stall_cnt_o (32 bits).
  - Increments each cycle the queue is non-empty and the head is blocked by zero credit.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset, not by flush.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dispatch_pkg:
  - FU index constants FU_ALU=0, FU_LSU=1, FU_MUL=2, FU_BR=3 and NUM_FU=4.
  - packed struct disp_entry_t {pc, fu, prs1, prs2, prd}.
- One natural sub-module: fu_credit_cnt, a single saturating credit counter with dispatch/free/flush inputs and zero/overflow flags. It is instantiated NUM_FU times.

Test Plan:
- Reset release, push ALU inst (pc=0x100, prd=7) → disp_valid_o=4'b0001 the next cycle with pc 0x100 and prd 7; ALU credit 4→3.
- Push 5 ALU insts with no rs_free → 4 dispatch; the 5th waits at the head with dec_ready_o=1 and count=1. Pulse rs_free_i[0] → 5th dispatches the next cycle.
- Exhaust MUL credits, head=MUL, next=ALU → ALU is not dispatched (in-order); queue fills to 2 and dec_ready_o=0.
- Same-cycle dispatch[1] and rs_free_i[1] at credit 2 → credit stays 2. rs_free_i[2] at credit 4 → credit stays 4 and err_o pulses once.
- dec_fu_i=4'b0101 pushed → no dispatch, err_o=1 for exactly one cycle.
- Queue holds 2 entries, LSU credit 1, flush_i=1 → no dispatch that cycle; next cycle empty, all credits 4, dec_ready_o=1. Assert reset_i=0 mid-stream → outputs clear immediately.
